bu_exec: RTL and testbench

- Branch execution unit directly downstream of rs_bu.
- Takes the issued head entry plus its operand values from the physical register file read, and resolves branch/jump outcome and target.
- Detects misprediction and produces redirect info for the ROB.
- For JAL/JALR, broadcasts the link value on its CDB port; the tag from that port feeds the reservation stations' reg*_rdy inputs.

---
 rtl/bu_exec.sv | 148 ++++++++++++++
 tb/tb_bu_exec.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bu_exec.sv
// Branch execution unit: resolves branch/JAL/JALR direction and target into a
// single result register with misprediction flag and JAL/JALR link broadcast.
// Optional retire statistics are compiled in with `define BU_STATS_EN.
module bu_exec #(
  parameter int XLEN   = 32,
  parameter int PREG_W = 7,
  parameter int ROB_W  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_in,
  output logic              fu_rdy,
  input  logic [XLEN-1:0]   pc,
  input  logic [6:0]        opcode,
  input  logic [2:0]        func3,
  input  logic [XLEN-1:0]   imm,
  input  logic [PREG_W-1:0] prd,
  input  logic [ROB_W-1:0]  rob_index,
  input  logic [XLEN-1:0]   rs1_val,
  input  logic [XLEN-1:0]   rs2_val,
  input  logic              pred_taken,
  input  logic [XLEN-1:0]   pred_target,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [ROB_W-1:0]  out_rob_index,
  output logic              out_mispredict,
  output logic              out_taken,
  output logic [XLEN-1:0]   out_redirect_pc,
  output logic              cdb_valid,
  output logic [PREG_W-1:0] cdb_tag,
  output logic [XLEN-1:0]   cdb_data,
`ifdef BU_STATS_EN
  output logic [31:0]       stat_branches,
  output logic [31:0]       stat_mispredicts,
`endif
  input  logic              flush
);

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  logic              r_valid;
  logic [ROB_W-1:0]  r_rob_index;
  logic              r_mispredict;
  logic              r_taken;
  logic [XLEN-1:0]   r_redirect_pc;
  logic              r_is_link;
  logic [PREG_W-1:0] r_tag;
  logic [XLEN-1:0]   r_link_data;

  logic            w_is_br;
  logic            w_is_link;
  logic            w_cond;
  logic            w_taken;
  logic [XLEN-1:0] w_pc4;
  logic [XLEN-1:0] w_target;
  logic [XLEN-1:0] w_redirect;
  logic            w_mispredict;
  logic            w_accept;

  always_comb begin
    w_is_br   = (opcode == OP_BRANCH);
    w_is_link = (opcode == OP_JAL) || (opcode == OP_JALR);
    w_pc4     = pc + XLEN'(4);
    w_cond    = 1'b0;
    case (func3)
      3'b000:  w_cond = (rs1_val == rs2_val);
      3'b001:  w_cond = (rs1_val != rs2_val);
      3'b100:  w_cond = ($signed(rs1_val) <  $signed(rs2_val));
      3'b101:  w_cond = ($signed(rs1_val) >= $signed(rs2_val));
      3'b110:  w_cond = (rs1_val <  rs2_val);
      3'b111:  w_cond = (rs1_val >= rs2_val);
      default: w_cond = 1'b0;
    endcase
    w_taken = (w_is_br && w_cond) || w_is_link;
    // JALR target comes from rs1 with the LSB forced to zero; everything else is PC-relative.
    if (opcode == OP_JALR)
      w_target = (rs1_val + imm) & {{(XLEN-1){1'b1}}, 1'b0};
    else
      w_target = pc + imm;
    w_redirect   = w_taken ? w_target : w_pc4;
    w_mispredict = (w_taken != pred_taken) || (w_taken && (w_target != pred_target));
  end

  assign fu_rdy   = !r_valid || out_ready;
  assign w_accept = valid_in && fu_rdy && !flush;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid       <= 1'b0;
      r_rob_index   <= '0;
      r_mispredict  <= 1'b0;
      r_taken       <= 1'b0;
      r_redirect_pc <= '0;
      r_is_link     <= 1'b0;
      r_tag         <= '0;
      r_link_data   <= '0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (w_accept) begin
      r_valid       <= 1'b1;
      r_rob_index   <= rob_index;
      r_mispredict  <= w_mispredict;
      r_taken       <= w_taken;
      r_redirect_pc <= w_redirect;
      r_is_link     <= w_is_link;
      r_tag         <= prd;
      r_link_data   <= w_pc4;
    end else if (out_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign out_valid       = r_valid;
  assign out_rob_index   = r_rob_index;
  assign out_mispredict  = r_mispredict;
  assign out_taken       = r_taken;
  assign out_redirect_pc = r_redirect_pc;
  assign cdb_valid       = r_valid && r_is_link;
  assign cdb_tag         = r_tag;
  assign cdb_data        = r_link_data;

`ifdef BU_STATS_EN
  logic [31:0] r_stat_branches;
  logic [31:0] r_stat_mispredicts;
  logic        w_retire;

  // A result flushed in the same cycle it would drain is discarded, not retired.
  assign w_retire = r_valid && out_ready && !flush;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stat_branches    <= '0;
      r_stat_mispredicts <= '0;
    end else if (w_retire) begin
      if (r_stat_branches != 32'hFFFF_FFFF)
        r_stat_branches <= r_stat_branches + 32'd1;
      if (r_mispredict && (r_stat_mispredicts != 32'hFFFF_FFFF))
        r_stat_mispredicts <= r_stat_mispredicts + 32'd1;
    end
  end

  assign stat_branches    = r_stat_branches;
  assign stat_mispredicts = r_stat_mispredicts;
`endif

endmodule

// File: tb/tb_bu_exec.sv
// Self-checking bench for bu_exec: directed vector table, handshake corner
// sequences, and randomized traffic against a behavioural reference model.
module tb_bu_exec;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_in;
  logic        fu_rdy;
  logic [31:0] pc;
  logic [6:0]  opcode;
  logic [2:0]  func3;
  logic [31:0] imm;
  logic [6:0]  prd;
  logic [3:0]  rob_index;
  logic [31:0] rs1_val, rs2_val;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        out_ready;
  logic        out_valid;
  logic [3:0]  out_rob_index;
  logic        out_mispredict;
  logic        out_taken;
  logic [31:0] out_redirect_pc;
  logic        cdb_valid;
  logic [6:0]  cdb_tag;
  logic [31:0] cdb_data;
  logic        flush;
`ifdef BU_STATS_EN
  logic [31:0] stat_branches, stat_mispredicts;
`endif

  bu_exec #(.XLEN(32), .PREG_W(7), .ROB_W(4)) dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .fu_rdy(fu_rdy),
    .pc(pc), .opcode(opcode), .func3(func3), .imm(imm), .prd(prd),
    .rob_index(rob_index), .rs1_val(rs1_val), .rs2_val(rs2_val),
    .pred_taken(pred_taken), .pred_target(pred_target), .out_ready(out_ready),
    .out_valid(out_valid), .out_rob_index(out_rob_index),
    .out_mispredict(out_mispredict), .out_taken(out_taken),
    .out_redirect_pc(out_redirect_pc), .cdb_valid(cdb_valid),
    .cdb_tag(cdb_tag), .cdb_data(cdb_data),
`ifdef BU_STATS_EN
    .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts),
`endif
    .flush(flush)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        pt;
    logic [31:0] ptgt;
    logic [6:0]  prd;
    logic [3:0]  rob;
    logic        e_taken;
    logic        e_misp;
    logic [31:0] e_redir;
    logic        e_cdb;
  } vec_t;

  localparam logic [6:0] BR = 7'b1100011, JAL = 7'b1101111, JALR = 7'b1100111;

  vec_t vecs[10];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input vec_t v);
    opcode = v.op; func3 = v.f3; pc = v.pc; imm = v.imm;
    rs1_val = v.rs1; rs2_val = v.rs2; pred_taken = v.pt;
    pred_target = v.ptgt; prd = v.prd; rob_index = v.rob;
  endtask

  // Reference: direct evaluation of the branch rules with plain arithmetic.
  function automatic void ref_model(
      input logic [6:0] op, input logic [2:0] f3, input logic [31:0] p,
      input logic [31:0] im, input logic [31:0] a, input logic [31:0] b,
      input logic pt, input logic [31:0] ptgt,
      output logic taken, output logic [31:0] redir, output logic misp,
      output logic link);
    logic [31:0] tgt;
    int sa, sb;
    sa = int'(a);
    sb = int'(b);
    link  = (op == JAL) || (op == JALR);
    taken = link;
    if (op == BR) begin
      case (f3)
        3'd0: taken = (a == b);
        3'd1: taken = (a != b);
        3'd4: taken = (sa < sb);
        3'd5: taken = !(sa < sb);
        3'd6: taken = (a < b);
        3'd7: taken = !(a < b);
        default: taken = 1'b0;
      endcase
    end
    if (op == JALR) tgt = ((a + im) >> 1) << 1;
    else            tgt = p + im;
    redir = taken ? tgt : p + 32'd4;
    misp  = (taken != pt) || (taken && (tgt != ptgt));
  endfunction

  task automatic check_out(input string tag, input logic [3:0] rob,
                           input logic taken, input logic misp,
                           input logic [31:0] redir, input logic link,
                           input logic [6:0] tg, input logic [31:0] ldata);
    chk({tag, ".out_valid"}, out_valid, 1);
    chk({tag, ".rob"}, out_rob_index, rob);
    chk({tag, ".taken"}, out_taken, taken);
    chk({tag, ".misp"}, out_mispredict, misp);
    chk({tag, ".redirect"}, out_redirect_pc, redir);
    chk({tag, ".cdb_valid"}, cdb_valid, link);
    chk({tag, ".cdb_tag"}, cdb_tag, tg);
    chk({tag, ".cdb_data"}, cdb_data, ldata);
  endtask

  logic        m_valid, m_taken, m_misp, m_link;
  logic [3:0]  m_rob;
  logic [31:0] m_redir, m_ldata;
  logic [6:0]  m_tag;

  initial begin
    //          op    f3  pc            imm           rs1           rs2           pt ptgt          prd rob tk ms redir         cdb
    vecs[0] = '{BR,   0, 32'h100,      32'h20,       32'd5,        32'd5,        0, 32'h0,       3,  1, 1, 1, 32'h120,      0};
    vecs[1] = '{BR,   4, 32'h300,      32'h40,       32'hFFFFFFFF, 32'd1,        1, 32'h340,     4,  2, 1, 0, 32'h340,      0};
    vecs[2] = '{BR,   6, 32'h300,      32'h40,       32'hFFFFFFFF, 32'd1,        1, 32'h340,     4,  3, 0, 1, 32'h304,      0};
    vecs[3] = '{JALR, 0, 32'h200,      32'h0,        32'h1003,     32'h0,        1, 32'h1002,    9,  4, 1, 0, 32'h1002,     1};
    vecs[4] = '{JAL,  0, 32'h400,      32'hFFFFFFF0, 32'h0,        32'h0,        1, 32'h3F0,     0,  5, 1, 0, 32'h3F0,      1};
    vecs[5] = '{7'h33,0, 32'h500,      32'h10,       32'd1,        32'd1,        1, 32'h510,     7,  6, 0, 1, 32'h504,      0};
    vecs[6] = '{BR,   1, 32'h600,      32'h10,       32'd7,        32'd7,        0, 32'h0,       2,  7, 0, 0, 32'h604,      0};
    vecs[7] = '{BR,   5, 32'h700,      32'h8,        32'd1,        32'hFFFFFFFF, 1, 32'h0,       1,  8, 1, 1, 32'h708,      0};
    vecs[8] = '{BR,   2, 32'h800,      32'h8,        32'd3,        32'd3,        0, 32'h0,       5,  9, 0, 0, 32'h804,      0};
    vecs[9] = '{BR,   7, 32'hFFFFFFF0, 32'h20,       32'd5,        32'd5,        1, 32'h10,      6, 10, 1, 0, 32'h10,       0};

    reset = 1; valid_in = 0; out_ready = 0; flush = 0;
    drive(vecs[0]);
    step(); step();
    chk("rst.out_valid", out_valid, 0);
    chk("rst.cdb_valid", cdb_valid, 0);
    chk("rst.redirect", out_redirect_pc, 0);
    chk("rst.rob", out_rob_index, 0);
    chk("rst.misp_taken", {out_mispredict, out_taken}, 0);
    chk("rst.cdb_fields", cdb_data | 32'(cdb_tag), 0);
    reset = 0;
    step();
    chk("post_rst.fu_rdy", fu_rdy, 1);
    chk("post_rst.out_valid", out_valid, 0);

    // Directed vector table, back to back with out_ready held high
    out_ready = 1;
    for (int i = 0; i < 10; i++) begin
      drive(vecs[i]);
      valid_in = 1;
      step();
      check_out($sformatf("vec%0d", i), vecs[i].rob, vecs[i].e_taken, vecs[i].e_misp,
                vecs[i].e_redir, vecs[i].e_cdb, vecs[i].prd, vecs[i].pc + 32'd4);
      $display("[TB] vec%0d op=%b f3=%0d taken=%0b misp=%0b redirect=%08h",
               i, vecs[i].op, vecs[i].f3, out_taken, out_mispredict, out_redirect_pc);
    end
    valid_in = 0;
    step();
    chk("drain.out_valid", out_valid, 0);

    // Backpressure: result held 3 cycles, second instruction waits
    drive(vecs[0]); valid_in = 1; out_ready = 1;
    step();
    drive(vecs[3]); rob_index = 4'd12; out_ready = 0;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("bp%0d.fu_rdy", c), fu_rdy, 0);
      check_out($sformatf("bp%0d", c), 4'd1, 1, 1, 32'h120, 0, 7'd3, 32'h104);
      step();
    end
    out_ready = 1;
    step();
    valid_in = 0;
    check_out("bp_second", 4'd12, 1, 0, 32'h1002, 1, 7'd9, 32'h204);
    $display("[TB] backpressure second result rob=%0d", out_rob_index);
    step();
    chk("bp_drain.out_valid", out_valid, 0);

    // Flush squashes a stalled JAL result and blocks a simultaneous accept
    drive(vecs[4]); valid_in = 1; out_ready = 1;
    step();
    chk("fl_pre.cdb_valid", cdb_valid, 1);
    drive(vecs[0]); out_ready = 0; flush = 1;
    step();
    flush = 0; valid_in = 0;
    chk("fl.out_valid", out_valid, 0);
    chk("fl.cdb_valid", cdb_valid, 0);
    step();
    chk("fl_after.out_valid", out_valid, 0);
    $display("[TB] flush sequence done");

`ifdef BU_STATS_EN
    reset = 1; step(); reset = 0;
    chk("st_rst.br", stat_branches, 0);
    chk("st_rst.mp", stat_mispredicts, 0);
    out_ready = 1;
    for (int i = 0; i < 4; i++) begin
      drive(vecs[i]); valid_in = 1;
      step();
      valid_in = 0;
      step();
    end
    drive(vecs[0]); valid_in = 1; out_ready = 0;
    step();
    valid_in = 0; out_ready = 1; flush = 1;
    step();
    flush = 0;
    chk("st.br", stat_branches, 4);
    chk("st.mp", stat_mispredicts, 2);
    reset = 1; step(); reset = 0;
    chk("st_clr.br", stat_branches, 0);
    chk("st_clr.mp", stat_mispredicts, 0);
    $display("[TB] stats sequence done");
`endif

    // Randomized traffic against the reference model
    m_valid = 0; m_taken = 0; m_misp = 0; m_link = 0;
    m_rob = 0; m_redir = 0; m_ldata = 0; m_tag = 0;
    for (int n = 0; n < 400; n++) begin
      logic acc, e_tk, e_ms, e_lk;
      logic [31:0] e_rd;
      int sel;
      sel = $urandom_range(0, 9);
      opcode = (sel < 6) ? BR : (sel < 8) ? JAL : (sel < 9) ? JALR : 7'($urandom);
      func3 = 3'($urandom);
      pc = $urandom & 32'hFFFFFFFC;
      imm = ($urandom_range(0, 3) == 0) ? $urandom : 32'($signed(12'($urandom)));
      rs1_val = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 3)) - 32'd1 : $urandom;
      rs2_val = ($urandom_range(0, 2) == 0) ? rs1_val : 32'($urandom_range(0, 3)) - 32'd1;
      prd = 7'($urandom); rob_index = 4'($urandom);
      pred_taken = 1'($urandom);
      ref_model(opcode, func3, pc, imm, rs1_val, rs2_val, 1'b1, 32'h0, e_tk, e_rd, e_ms, e_lk);
      pred_target = ($urandom_range(0, 1) == 0) ? e_rd : $urandom;
      valid_in = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush = ($urandom_range(0, 15) == 0);
      #1;
      chk("rnd.fu_rdy", fu_rdy, !m_valid || out_ready);
      acc = valid_in && (!m_valid || out_ready) && !flush;
      ref_model(opcode, func3, pc, imm, rs1_val, rs2_val, pred_taken, pred_target,
                e_tk, e_rd, e_ms, e_lk);
      step();
      if (flush) m_valid = 0;
      else if (acc) begin
        m_valid = 1; m_rob = rob_index; m_taken = e_tk; m_misp = e_ms;
        m_redir = e_rd; m_link = e_lk; m_tag = prd; m_ldata = pc + 32'd4;
        $display("[TB] rnd%0d op=%b f3=%0d taken=%0b misp=%0b redirect=%08h",
                 n, opcode, func3, e_tk, e_ms, e_rd);
      end else if (out_ready) m_valid = 0;
      if (m_valid)
        check_out("rnd", m_rob, m_taken, m_misp, m_redir, m_link, m_tag, m_ldata);
      else begin
        chk("rnd.out_valid", out_valid, 0);
        chk("rnd.cdb_valid", cdb_valid, 0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
